// File: rtl/mem_req_master.sv
// mem_req_master
//
// Request master placed directly in front of the 16-bit single-port
// handshake SRAM. Client commands enter a small FIFO. An FSM pops them one at
// a time and issues each to the SRAM as a single-cycle valid pulse. It then
// waits for the SRAM's registered ready and returns read data through a
// backpressured response port. A per-access timeout covers a missing ready.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active low
//   cmd_valid_i   command present
//   cmd_ready_o   command FIFO not full
//   cmd_wr_i      1 = write, 0 = read
//   cmd_addr_i    command address
//   cmd_wdata_i   write data (ignored for reads)
//   mem_valid_o   single-cycle request strobe to the SRAM
//   mem_wr_rd_o   SRAM write/read select (1 = write)
//   mem_addr_o    SRAM address
//   mem_wdata_o   SRAM write data
//   mem_ready_i   SRAM registered ready
//   mem_rdata_i   SRAM read data
//   rsp_valid_o   read response available
//   rsp_ready_i   consumer accepts response
//   rsp_data_o    read data (0 for a timed-out read)
//   rsp_err_o     response comes from a timed-out read
//   err_o         sticky timeout flag, cleared only by reset
//   busy_o        FSM not idle or FIFO not empty
module mem_req_master #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [WIDTH-1:0]      cmd_wdata_i,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TO_W    = $clog2(TIMEOUT);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  logic [1:0]         state;
  logic [TO_W-1:0]    to_cnt;

  logic                  head_wr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [WIDTH-1:0]      head_wdata;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = cmd_valid_i && !full;
  // Only the idle FSM consumes a command, so the next pop never overlaps an
  // access that is still in flight.
  assign pop   = (state == S_IDLE) && !empty;

  assign cmd_ready_o = !full;
  assign busy_o      = (state != S_IDLE) || !empty;

  assign {head_wr, head_addr, head_wdata} = fifo_mem[rd_ptr];

  // NOTE: the storage array has no reset; validity is carried entirely by the
  // pointers and occupancy count, so clearing the data would buy nothing.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_wr_i, cmd_addr_i, cmd_wdata_i};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      mem_valid_o <= 1'b0;
      mem_wr_rd_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            // The request fields stay registered until the next pop.
            mem_wr_rd_o <= head_wr;
            mem_addr_o  <= head_addr;
            mem_wdata_o <= head_wdata;
            mem_valid_o <= 1'b1;
            state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Dropping valid here guarantees the SRAM sees exactly one request.
          mem_valid_o <= 1'b0;
          to_cnt      <= '0;
          state       <= S_WAIT;
        end

        S_WAIT: begin
          if (mem_ready_i) begin
            if (mem_wr_rd_o) begin
              state <= S_IDLE;
            end else begin
              rsp_data_o  <= mem_rdata_i;
              rsp_err_o   <= 1'b0;
              rsp_valid_o <= 1'b1;
              state       <= S_RESP;
            end
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            // Timeout: a write is silently dropped, a read returns an error.
            err_o <= 1'b1;
            if (mem_wr_rd_o) begin
              state <= S_IDLE;
            end else begin
              rsp_data_o  <= '0;
              rsp_err_o   <= 1'b1;
              rsp_valid_o <= 1'b1;
              state       <= S_RESP;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_master.sv
// tb_mem_req_master
//
// Self-checking bench for mem_req_master. A behavioural SRAM with a registered
// ready answers the requests. A shadow memory predicts read data, and the
// expected responses are queued when each read command is accepted. A monitor
// pops and compares them when a response handshake occurs. The monitor also
// checks single-cycle request pulses and response stability under stall.
module tb_mem_req_master;

  localparam int WIDTH   = 16;
  localparam int AW      = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic            clk_i;
  logic            rst_i;
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic            cmd_wr_i;
  logic [AW-1:0]   cmd_addr_i;
  logic [WIDTH-1:0] cmd_wdata_i;
  logic            mem_valid_o;
  logic            mem_wr_rd_o;
  logic [AW-1:0]   mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic            mem_ready_i;
  logic [WIDTH-1:0] mem_rdata_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [WIDTH-1:0] rsp_data_o;
  logic            rsp_err_o;
  logic            err_o;
  logic            busy_o;

  mem_req_master #(
    .WIDTH(WIDTH), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .err_o(err_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Behavioural SRAM: samples valid on a rising edge, answers with a
  // one-cycle registered ready. ready_en lets a test suppress the ready.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sram [16];
  logic             ready_q;
  logic [WIDTH-1:0] rdata_q;
  logic             ready_en;

  always @(posedge clk_i) begin
    ready_q <= mem_valid_o;
    if (mem_valid_o) begin
      if (mem_wr_rd_o) sram[mem_addr_o] <= mem_wdata_o;
      else             rdata_q <= sram[mem_addr_o];
    end
  end

  assign mem_ready_i = ready_q & ready_en;
  assign mem_rdata_i = rdata_q;

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } rsp_t;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] exp_rdata;
  } vec_t;

  rsp_t             sb [$];
  rsp_t             sb_head;
  logic [WIDTH-1:0] ref_mem [16];
  logic             expect_timeout;
  vec_t             vecs [10];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive one command starting at a falling edge. Returns on the falling edge
  // after the rising edge that accepted it.
  task automatic push(input logic wr, input logic [AW-1:0] addr, input logic [WIDTH-1:0] wd);
    int budget;
    budget      = 0;
    cmd_valid_i = 1'b1;
    cmd_wr_i    = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    while (!cmd_ready_o && budget < 200) begin
      @(negedge clk_i);
      budget++;
    end
    check("push_accept", 32'(cmd_ready_o), 1);
    if (cmd_ready_o) begin
      @(negedge clk_i);
      if (wr) ref_mem[addr] = wd;
      else if (expect_timeout) sb.push_back(rsp_t'{err: 1'b1, data: '0});
      else sb.push_back(rsp_t'{err: 1'b0, data: ref_mem[addr]});
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((busy_o || rsp_valid_o) && b < 100) begin
      @(negedge clk_i);
      b++;
    end
    check("idle_reached", 32'(busy_o), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples just after the falling edge, when the bench's inputs for
  // the next rising edge are already settled.
  // ---------------------------------------------------------------------------
  logic             prev_mv;
  logic             prev_stall;
  logic [WIDTH-1:0] prev_data;
  logic             prev_err;

  initial begin
    prev_mv    = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i) begin
        prev_mv    = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (mem_valid_o) check("mem_valid_single_cycle", 32'(prev_mv), 0);
        if (prev_stall) begin
          check("stall_hold_valid", 32'(rsp_valid_o), 1);
          check("stall_hold_data", 32'(rsp_data_o), 32'(prev_data));
          check("stall_hold_err", 32'(rsp_err_o), 32'(prev_err));
        end
        if (rsp_valid_o && rsp_ready_i) begin
          check("rsp_expected_present", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            sb_head = sb.pop_front();
            check("rsp_data", 32'(rsp_data_o), 32'(sb_head.data));
            check("rsp_err", 32'(rsp_err_o), 32'(sb_head.err));
          end
        end
        prev_mv    = mem_valid_o;
        prev_stall = rsp_valid_o && !rsp_ready_i;
        prev_data  = rsp_data_o;
        prev_err   = rsp_err_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected end earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int mv_seen;
  int rv_seen;
  int wb;

  initial begin
    rst_i          = 1'b0;
    cmd_valid_i    = 1'b0;
    cmd_wr_i       = 1'b0;
    cmd_addr_i     = '0;
    cmd_wdata_i    = '0;
    rsp_ready_i    = 1'b1;
    ready_en       = 1'b1;
    expect_timeout = 1'b0;

    vecs[0] = '{addr: 4'd0, wdata: 16'h1234, exp_rdata: 16'h1234};
    vecs[1] = '{addr: 4'd1, wdata: 16'hFFFF, exp_rdata: 16'hFFFF};
    vecs[2] = '{addr: 4'd2, wdata: 16'h0000, exp_rdata: 16'h0000};
    vecs[3] = '{addr: 4'd3, wdata: 16'hBEEF, exp_rdata: 16'hBEEF};
    vecs[4] = '{addr: 4'd4, wdata: 16'h8001, exp_rdata: 16'h8001};
    vecs[5] = '{addr: 4'd5, wdata: 16'h5555, exp_rdata: 16'h5555};
    vecs[6] = '{addr: 4'd6, wdata: 16'hAAAA, exp_rdata: 16'hAAAA};
    vecs[7] = '{addr: 4'd7, wdata: 16'h0F0F, exp_rdata: 16'h0F0F};
    vecs[8] = '{addr: 4'd8, wdata: 16'hC3C3, exp_rdata: 16'hC3C3};
    vecs[9] = '{addr: 4'd9, wdata: 16'h7E81, exp_rdata: 16'h7E81};

    // Reset state
    #3;
    check("rst_cmd_ready", 32'(cmd_ready_o), 1);
    check("rst_mem_valid", 32'(mem_valid_o), 0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Write then read with latency checks
    push(1'b1, 4'd3, 16'hA5A5);
    wait_idle();
    push(1'b0, 4'd3, 16'h0);
    check("lat_n0_rsp_valid", 32'(rsp_valid_o), 0);
    @(negedge clk_i);
    check("lat_n1_mem_valid", 32'(mem_valid_o), 1);
    check("lat_n1_mem_wr_rd", 32'(mem_wr_rd_o), 0);
    check("lat_n1_mem_addr", 32'(mem_addr_o), 3);
    @(negedge clk_i);
    check("lat_n2_mem_valid", 32'(mem_valid_o), 0);
    check("lat_n2_rsp_valid", 32'(rsp_valid_o), 0);
    @(negedge clk_i);
    check("lat_n3_rsp_valid", 32'(rsp_valid_o), 1);
    check("lat_n3_rsp_data", 32'(rsp_data_o), 32'h0000_A5A5);
    check("lat_n3_rsp_err", 32'(rsp_err_o), 0);
    wait_idle();
    check("mem_addr_hold", 32'(mem_addr_o), 3);

    // Table-driven write/read pairs, wrapping the FIFO pointers
    for (int i = 0; i < 10; i++) begin
      push(1'b1, vecs[i].addr, vecs[i].wdata);
      push(1'b0, vecs[i].addr, 16'h0);
      wb = 0;
      while (!rsp_valid_o && wb < 50) begin
        @(negedge clk_i);
        wb++;
      end
      check("wrap_rsp_seen", 32'(rsp_valid_o), 1);
      check("wrap_rdata", 32'(rsp_data_o), 32'(vecs[i].exp_rdata));
      wait_idle();
    end

    // FIFO full under response backpressure
    rsp_ready_i = 1'b0;
    push(1'b0, 4'd3, 16'h0);
    push(1'b0, 4'd0, 16'h0);
    push(1'b0, 4'd9, 16'h0);
    push(1'b0, 4'd5, 16'h0);
    push(1'b0, 4'd7, 16'h0);
    check("full_cmd_ready", 32'(cmd_ready_o), 0);
    check("full_busy", 32'(busy_o), 1);
    check("full_stall_valid", 32'(rsp_valid_o), 1);
    check("full_stall_data", 32'(rsp_data_o), 32'(vecs[3].exp_rdata));
    fork
      push(1'b0, 4'd1, 16'h0);
      begin
        repeat (6) @(negedge clk_i);
        rsp_ready_i = 1'b1;
      end
    join
    wait_idle();
    check("full_drained", sb.size(), 0);

    // Timeout on a read
    ready_en       = 1'b0;
    expect_timeout = 1'b1;
    push(1'b0, 4'd2, 16'h0);
    expect_timeout = 1'b0;
    @(negedge clk_i);
    check("to_mem_valid", 32'(mem_valid_o), 1);
    repeat (TIMEOUT) @(negedge clk_i);
    check("to_err_before", 32'(err_o), 0);
    check("to_rsp_before", 32'(rsp_valid_o), 0);
    @(negedge clk_i);
    check("to_err_fire", 32'(err_o), 1);
    check("to_rsp_valid", 32'(rsp_valid_o), 1);
    check("to_rsp_err", 32'(rsp_err_o), 1);
    check("to_rsp_data", 32'(rsp_data_o), 0);
    ready_en = 1'b1;
    wait_idle();
    push(1'b1, 4'd4, 16'h5A5A);
    push(1'b0, 4'd4, 16'h0);
    wait_idle();
    check("err_sticky", 32'(err_o), 1);

    // Reset while an access is in WAIT with two commands queued
    push(1'b0, 4'd1, 16'h0);
    push(1'b0, 4'd2, 16'h0);
    push(1'b0, 4'd3, 16'h0);
    check("mid_busy", 32'(busy_o), 1);
    #2;
    rst_i = 1'b0;
    #1;
    check("async_mem_valid", 32'(mem_valid_o), 0);
    check("async_rsp_valid", 32'(rsp_valid_o), 0);
    check("async_busy", 32'(busy_o), 0);
    check("async_cmd_ready", 32'(cmd_ready_o), 1);
    check("async_err", 32'(err_o), 0);
    sb.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i   = 1'b1;
    mv_seen = 0;
    rv_seen = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (mem_valid_o) mv_seen++;
      if (rsp_valid_o) rv_seen++;
    end
    check("post_rst_busy", 32'(busy_o), 0);
    check("post_rst_no_req", mv_seen, 0);
    check("post_rst_no_rsp", rv_seen, 0);
    check("sb_final_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_req_master.md
# mem_req_master

Request master that sits directly upstream of the team's 16-bit single-port handshake SRAM. It accepts read/write commands from a client through a 4-entry command FIFO and issues them to the SRAM one at a time as single-cycle `valid` pulses. It waits for the SRAM's registered `ready`, captures the read data, and returns read results through a backpressured response port. A per-access timeout covers a missing `ready`.

## Interface
Parameters:
- WIDTH, 16, data width; matches the SRAM.
- ADDR_WIDTH, 4, address width; matches the SRAM.
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2, ≥2.
- TIMEOUT, 8, WAIT cycles without `mem_ready_i` before aborting; ≥2.

Ports:
- clk_i, input, 1: single clock, rising edge.
- rst_i, input, 1: reset, **asynchronous, active-low**.
- cmd_valid_i, input, 1: command present.
- cmd_ready_o, output, 1: FIFO can accept; equals !full.
- cmd_wr_i, input, 1: 1 = write, 0 = read.
- cmd_addr_i, input, ADDR_WIDTH: command address.
- cmd_wdata_i, input, WIDTH: write data; ignored for reads.
- mem_valid_o, output, 1: request strobe to SRAM `valid_i`.
- mem_wr_rd_o, output, 1: to SRAM `wr_rd_i`.
- mem_addr_o, output, ADDR_WIDTH: to SRAM `addr_i`.
- mem_wdata_o, output, WIDTH: to SRAM `wdata_i`.
- mem_ready_i, input, 1: from SRAM `ready_o`.
- mem_rdata_i, input, WIDTH: from SRAM `rdata_o`.
- rsp_valid_o, output, 1: read response available.
- rsp_ready_i, input, 1: consumer accepts response.
- rsp_data_o, output, WIDTH: read data.
- rsp_err_o, output, 1: response is from a timed-out read; data is 0.
- err_o, output, 1: sticky timeout flag; cleared only by reset.
- busy_o, output, 1: FSM not in IDLE, or FIFO not empty.

## Operation
- Reset (rst_i=0, asynchronous):
  - All outputs 0, except cmd_ready_o=1.
  - FIFO empty, FSM in IDLE, timeout counter 0.
- FIFO:
  - Push when cmd_valid_i && cmd_ready_o.
  - Pop only by the FSM in IDLE.
  - Push and pop in the same cycle are both honoured.
  - A push while full is impossible, because cmd_ready_o=0.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, register it onto mem_wr_rd_o/mem_addr_o/mem_wdata_o, set mem_valid_o=1, and go to ISSUE.
  - ISSUE: lasts exactly one cycle. Clear mem_valid_o, clear the counter, go to WAIT.
    - mem_valid_o is never high for two consecutive cycles, so the SRAM performs each access exactly once.
  - WAIT: mem_valid_o=0.
    - If mem_ready_i=1: a read captures mem_rdata_i into rsp_data_o, sets rsp_valid_o=1 and rsp_err_o=0, and goes to RESP; a write goes to IDLE.
    - Else: increment the counter. When the counter reaches TIMEOUT-1 with no ready, set err_o=1.
    - On that timeout, a read goes to RESP with rsp_data_o=0 and rsp_err_o=1; a write goes to IDLE and is dropped.
  - RESP: hold rsp_valid_o, rsp_data_o and rsp_err_o stable. When rsp_ready_i=1, clear rsp_valid_o and go to IDLE.
- Writes produce no response.
- mem_addr_o, mem_wr_rd_o and mem_wdata_o hold their values until the next pop.
- Reset mid-operation aborts immediately:
  - Pending FIFO entries are discarded.
  - mem_valid_o drops asynchronously.
  - An outstanding SRAM access is not retried.

## Timing
- Command pushed at edge E (FIFO empty, FSM in IDLE):
  - E+1: mem_valid_o=1.
  - E+2: SRAM samples the request and raises ready; mem_valid_o=0.
  - E+3: FSM samples ready. For a read, rsp_valid_o=1 after E+3.
- Read latency, push edge to rsp_valid_o: 3 cycles.
- Throughput:
  - One write per 3 cycles: IDLE, ISSUE, WAIT.
  - One read per 4 cycles plus response stall cycles.
- The next pop happens on the edge after the FSM re-enters IDLE. It is not overlapped with WAIT or RESP.
- rsp_valid_o stays asserted indefinitely while rsp_ready_i=0. During that time the FIFO keeps accepting until full.
- Timeout fires at the TIMEOUT-th WAIT edge without ready: 1+TIMEOUT cycles after mem_valid_o rises.

## Test plan
- Reset then idle: with rst_i=0, check cmd_ready_o=1, mem_valid_o=0, rsp_valid_o=0, err_o=0, busy_o=0. Assert rst_i asynchronously mid-cycle and confirm outputs clear without a clock edge.
- Write then read: write addr 3 data 0xA5A5, then read addr 3 with rsp_ready_i=1.
  - Expect mem_valid_o pulses of exactly 1 cycle each.
  - Expect rsp_data_o=0xA5A5, rsp_err_o=0.
  - Expect rsp_valid_o 3 cycles after the read push.
- FIFO full: with rsp_ready_i=0, push 6 reads back-to-back.
  - cmd_ready_o drops after the FIFO fills; the first read is already popped into the FSM.
  - The stall holds rsp_data_o stable.
  - Release rsp_ready_i and confirm all reads return in order.
- Wrap-around: push and pop 10 alternating write/read pairs to addrs 0..9, forcing pointer wrap. All read data must match.
- Timeout: tie mem_ready_i=0 and issue a read.
  - err_o rises 1+TIMEOUT(=9) cycles after mem_valid_o rises.
  - rsp_valid_o=1 with rsp_err_o=1 and rsp_data_o=0.
  - err_o stays 1 through subsequent successful accesses until reset.
- Reset mid-read: assert rst_i=0 during WAIT with 2 entries queued. After release, busy_o=0 and no response or memory request appears.
